// File: rtl/seg4_scan_if.sv
// Multiplexed 7-segment scan bus plus the decoded readback results.
// The display or bench drives the bus as master; the decoder is the slave.
interface seg4_scan_if;
  logic [7:0]  sm_seg;
  logic [3:0]  sm_bit;
  logic [13:0] num_out;
  logic [15:0] bcd_out;
  logic        num_valid;
  logic        seg_err;
  logic        frame_err;

  modport master (
    output sm_seg, sm_bit,
    input  num_out, bcd_out, num_valid, seg_err, frame_err
  );

  modport slave (
    input  sm_seg, sm_bit,
    output num_out, bcd_out, num_valid, seg_err, frame_err
  );
endinterface

// File: rtl/seg4_scan_decoder.sv
// Passive receiver for the 4-digit 7-segment scan bus: filter, decode, assemble and BCD->binary.
// Latency: digit3 accepted in cycle T gives num_valid in T+5; no backpressure (pure bus monitor).
module seg4_scan_decoder #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 262143
) (
  input  logic       clk_24m,
  input  logic       rst_n,
  seg4_scan_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_CONVERT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [3:0]      bit_q;
  logic [7:0]      seg_q;
  logic [SW-1:0]   settle_cnt;
  logic            sampled;
  logic [1:0]      state;
  logic [1:0]      exp_idx;
  logic [1:0]      conv_idx;
  logic [3:0][3:0] slot;
  logic            bad;
  logic [TW-1:0]   tmo_cnt;
  logic [13:0]     acc;
  logic [13:0]     num_q;
  logic [15:0]     bcd_q;
  logic            valid_q;
  logic            seg_err_q;
  logic            frame_err_q;

  logic            bit_onehot;
  logic [1:0]      dig_idx;
  logic            dec_ok;
  logic [3:0]      dec_val;
  logic            accept;
  logic            bit_chg;
  logic            seg_chg;
  logic [13:0]     acc_nxt;

  always_comb begin
    bit_onehot = 1'b1;
    dig_idx    = 2'd0;
    case (bit_q)
      4'b1110: dig_idx = 2'd0;
      4'b1101: dig_idx = 2'd1;
      4'b1011: dig_idx = 2'd2;
      4'b0111: dig_idx = 2'd3;
      default: bit_onehot = 1'b0;
    endcase
  end

  // Full byte compare: a lit dp makes the pattern undecodable.
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    case (seg_q)
      8'hc0: dec_val = 4'd0;
      8'hf9: dec_val = 4'd1;
      8'ha4: dec_val = 4'd2;
      8'hb0: dec_val = 4'd3;
      8'h99: dec_val = 4'd4;
      8'h92: dec_val = 4'd5;
      8'h82: dec_val = 4'd6;
      8'hf8: dec_val = 4'd7;
      8'h80: dec_val = 4'd8;
      8'h90: dec_val = 4'd9;
      default: dec_ok = 1'b0;
    endcase
  end

  assign bit_chg = (bus.sm_bit != bit_q);
  assign seg_chg = (bus.sm_seg != seg_q);
  assign accept  = (settle_cnt == SETTLE_MAX) && bit_onehot && !sampled &&
                   ((state == ST_IDLE) || (state == ST_COLLECT));
  assign acc_nxt = (acc << 3) + (acc << 1) + {10'd0, slot[conv_idx]};

  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      bit_q       <= 4'hf;
      seg_q       <= 8'hff;
      settle_cnt  <= '0;
      sampled     <= 1'b0;
      state       <= ST_IDLE;
      exp_idx     <= 2'd0;
      conv_idx    <= 2'd0;
      slot        <= '0;
      bad         <= 1'b0;
      tmo_cnt     <= '0;
      acc         <= '0;
      num_q       <= '0;
      bcd_q       <= '0;
      valid_q     <= 1'b0;
      seg_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bit_q       <= bus.sm_bit;
      seg_q       <= bus.sm_seg;
      valid_q     <= 1'b0;
      seg_err_q   <= 1'b0;
      frame_err_q <= 1'b0;

      if (bit_chg || seg_chg)
        settle_cnt <= '0;
      else if (settle_cnt != SETTLE_MAX)
        settle_cnt <= settle_cnt + 1'b1;

      // One sample per digit dwell: only a new digit select re-arms sampling.
      if (bit_chg)
        sampled <= 1'b0;
      else if (accept)
        sampled <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept && (dig_idx == 2'd0)) begin
            slot[0] <= dec_val;
            bad     <= !dec_ok;
            exp_idx <= 2'd1;
            tmo_cnt <= '0;
            state   <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (accept) begin
            if (dig_idx == exp_idx) begin
              slot[dig_idx] <= dec_val;
              tmo_cnt       <= '0;
              if (exp_idx == 2'd3) begin
                if (bad || !dec_ok) begin
                  seg_err_q <= 1'b1;
                  state     <= ST_IDLE;
                end else begin
                  acc      <= '0;
                  conv_idx <= 2'd3;
                  state    <= ST_CONVERT;
                end
              end else begin
                exp_idx <= exp_idx + 1'b1;
                bad     <= bad | !dec_ok;
              end
            end else begin
              frame_err_q <= 1'b1;
              state       <= ST_IDLE;
            end
          end else if (tmo_cnt == TIMEOUT_MAX) begin
            frame_err_q <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        // Horner over d3..d0; the last step lands straight in the output registers.
        ST_CONVERT: begin
          acc      <= acc_nxt;
          conv_idx <= conv_idx - 1'b1;
          if (conv_idx == 2'd0) begin
            num_q   <= acc_nxt;
            bcd_q   <= slot;
            valid_q <= 1'b1;
            state   <= ST_DONE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.num_out   = num_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.num_valid = valid_q;
  assign bus.seg_err   = seg_err_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_seg4_scan_decoder.sv
// Randomized scan-bus stimulus checked against a digit-level reference model.
module tb_seg4_scan_decoder;

  localparam int SETTLE_CYC  = 16;
  localparam int TIMEOUT_CYC = 1000;
  localparam int LATENCY     = SETTLE_CYC + 5;

  logic clk_24m = 1'b0;
  logic rst_n   = 1'b0;

  seg4_scan_if bus();

  seg4_scan_decoder #(
    .SETTLE_CYC (SETTLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_24m(clk_24m),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #21 clk_24m = ~clk_24m;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_seg = 0;
  int n_frm = 0;
  int valid_cyc = 0;
  int drive_cyc = 0;
  int exp_num = 0;
  logic [15:0] exp_bcd = 16'h0;
  logic [7:0] seg_tab [10] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99,
                               8'h92, 8'h82, 8'hf8, 8'h80, 8'h90};

  always @(posedge clk_24m) cyc <= cyc + 1;

  always @(negedge clk_24m) begin
    if (rst_n) begin
      if (bus.num_valid) begin
        n_valid   <= n_valid + 1;
        valid_cyc <= cyc;
      end
      if (bus.seg_err)   n_seg <= n_seg + 1;
      if (bus.frame_err) n_frm <= n_frm + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int seg2dig(input logic [7:0] s);
    for (int i = 0; i < 10; i++)
      if (seg_tab[i] == s) return i;
    return -1;
  endfunction

  // Called at a falling edge; returns n falling edges later.
  task automatic hold(input logic [3:0] b, input logic [7:0] s, input int n);
    bus.sm_bit = b;
    bus.sm_seg = s;
    drive_cyc  = cyc;
    repeat (n) @(negedge clk_24m);
  endtask

  task automatic send_digit(input int idx, input logic [7:0] s, input int dwell,
                            input int glen, input logic [3:0] gbit);
    logic [3:0] b;
    logic [3:0] gb;
    b  = ~(4'b0001 << idx);
    gb = (gbit == b) ? ~b : gbit;
    if (glen > 0) begin
      hold(b, s, 3);
      hold(gb, 8'($urandom_range(0, 255)), glen);
    end
    hold(b, s, dwell);
  endtask

  task automatic run_frame(input logic [15:0] bcd, input int bad_pos, input logic [7:0] bad_byte,
                           input int dwell, input int glen0, input bit rnd_glitch, input string tag);
    logic [7:0]  s [4];
    logic [15:0] mb;
    logic [3:0]  gb;
    int d, val, v0, s0, f0, dw, gl;
    bit ok;
    ok  = 1'b1;
    val = 0;
    mb  = 16'h0;
    for (int i = 0; i < 4; i++) begin
      s[i] = seg_tab[bcd[4*i +: 4]];
      if (i == bad_pos) s[i] = bad_byte;
    end
    for (int i = 3; i >= 0; i--) begin
      d = seg2dig(s[i]);
      if (d < 0) ok = 1'b0;
      else begin
        val = val * 10 + d;
        mb[4*i +: 4] = 4'(d);
      end
    end
    v0 = n_valid; s0 = n_seg; f0 = n_frm;
    for (int i = 0; i < 4; i++) begin
      dw = (dwell > 0) ? dwell : $urandom_range(30, 120);
      gl = 0;
      gb = 4'($urandom_range(0, 15));
      if (i == 0 && glen0 > 0) begin
        gl = glen0;
        gb = 4'b1101;
      end else if (rnd_glitch && $urandom_range(0, 2) == 0) begin
        gl = $urandom_range(1, 10);
      end
      send_digit(i, s[i], dw, gl, gb);
    end
    repeat (10) @(negedge clk_24m);
    if (ok) begin
      exp_num = val;
      exp_bcd = mb;
    end
    chk({tag, ".valid"},   n_valid - v0, ok ? 1 : 0);
    chk({tag, ".seg_err"}, n_seg - s0,   ok ? 0 : 1);
    chk({tag, ".frm_err"}, n_frm - f0,   0);
    chk({tag, ".num"},     int'(bus.num_out), exp_num);
    chk({tag, ".bcd"},     int'(bus.bcd_out), int'(exp_bcd));
    if (ok) chk({tag, ".latency"}, valid_cyc - drive_cyc, LATENCY);
  endtask

  initial begin
    int v0, f0, s0, bp;
    logic [15:0] rb;
    bus.sm_bit = 4'hf;
    bus.sm_seg = 8'hff;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_24m);
    chk("rst.num",   int'(bus.num_out),   0);
    chk("rst.bcd",   int'(bus.bcd_out),   0);
    chk("rst.valid", int'(bus.num_valid), 0);
    chk("rst.err",   int'({bus.seg_err, bus.frame_err}), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_24m);

    run_frame(16'h0123, -1, 8'h00, 100, 0, 1'b0, "f0123");
    run_frame(16'h0123, -1, 8'h00, 100, 5, 1'b0, "glitch");
    run_frame(16'h0456, 2, 8'hff, 60, 0, 1'b0, "segbad");

    v0 = n_valid; f0 = n_frm; s0 = n_seg;
    send_digit(0, seg_tab[4], 40, 0, 4'h0);
    send_digit(2, seg_tab[4], 40, 0, 4'h0);
    chk("skip.frm_err", n_frm - f0, 1);
    chk("skip.valid",   n_valid - v0, 0);
    chk("skip.seg_err", n_seg - s0, 0);
    chk("skip.num",     int'(bus.num_out), exp_num);
    run_frame(16'h9999, -1, 8'h00, 50, 0, 1'b0, "f9999");

    v0 = n_valid; f0 = n_frm;
    send_digit(3, seg_tab[1], 40, 0, 4'h0);
    chk("idle_ign.frm_err", n_frm - f0, 0);
    send_digit(0, seg_tab[1], 40, 0, 4'h0);
    send_digit(1, seg_tab[2], TIMEOUT_CYC + 100, 0, 4'h0);
    chk("timeout.frm_err", n_frm - f0, 1);
    hold(4'hf, 8'hff, 20);
    chk("timeout.valid", n_valid - v0, 0);
    chk("timeout.num",   int'(bus.num_out), exp_num);

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++) rb[4*i +: 4] = 4'($urandom_range(0, 9));
      bp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      run_frame(rb, bp, 8'($urandom_range(0, 255)), 0, 0, 1'b1, $sformatf("rnd%0d", k));
    end
    run_frame(16'h0777, -1, 8'h00, 40, 0, 1'b0, "f0777");

    send_digit(0, seg_tab[2], 40, 0, 4'h0);
    send_digit(1, seg_tab[4], 20, 0, 4'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst.num",   int'(bus.num_out),   0);
    chk("midrst.bcd",   int'(bus.bcd_out),   0);
    chk("midrst.valid", int'(bus.num_valid), 0);
    chk("midrst.err",   int'({bus.seg_err, bus.frame_err}), 0);
    exp_num = 0;
    exp_bcd = 16'h0;
    repeat (3) @(negedge clk_24m);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_24m);
    run_frame(16'h0042, -1, 8'h00, 60, 0, 1'b0, "f0042");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
